// File: rtl/reg_file_arbiter.sv
// Two-client arbiter and access sequencer for the 32x32 dual-read register file.
// Define REG_ARB_FIXED_PRIORITY_EN to make client 0 win every contention (default: round-robin).
module reg_file_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr_r1_0,
  input  logic [ADDR_WIDTH-1:0] addr_r1_1,
  input  logic [ADDR_WIDTH-1:0] addr_r2_0,
  input  logic [ADDR_WIDTH-1:0] addr_r2_1,
  input  logic [ADDR_WIDTH-1:0] addr_w_0,
  input  logic [ADDR_WIDTH-1:0] addr_w_1,
  input  logic [DATA_WIDTH-1:0] data_w_0,
  input  logic [DATA_WIDTH-1:0] data_w_1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1_0,
  output logic [DATA_WIDTH-1:0] rdata1_1,
  output logic [DATA_WIDTH-1:0] rdata2_0,
  output logic [DATA_WIDTH-1:0] rdata2_1,
  output logic                  rf_read,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_addr_r1,
  output logic [ADDR_WIDTH-1:0] rf_addr_r2,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  input  logic [DATA_WIDTH-1:0] rf_data_r1,
  input  logic [DATA_WIDTH-1:0] rf_data_r2,
  output logic                  busy,
  output logic                  gnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t                state, state_d;
  logic                  gnt_d, win;
  logic                  rf_read_d, rf_write_d, ack0_d, ack1_d, busy_d;
  logic [ADDR_WIDTH-1:0] rf_addr_r1_d, rf_addr_r2_d, rf_addr_w_d;
  logic [DATA_WIDTH-1:0] rf_data_w_d;
  logic [DATA_WIDTH-1:0] rdata1_0_d, rdata1_1_d, rdata2_0_d, rdata2_1_d;

  // Winner of the IDLE grant edge; gnt holds the previous grant.
`ifdef REG_ARB_FIXED_PRIORITY_EN
  assign win = ~req0;
`else
  assign win = (req0 & req1) ? ~gnt : req1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b1;
      rf_read    <= 1'b0;
      rf_write   <= 1'b0;
      rf_addr_r1 <= '0;
      rf_addr_r2 <= '0;
      rf_addr_w  <= '0;
      rf_data_w  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata1_0   <= '0;
      rdata1_1   <= '0;
      rdata2_0   <= '0;
      rdata2_1   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      rf_read    <= rf_read_d;
      rf_write   <= rf_write_d;
      rf_addr_r1 <= rf_addr_r1_d;
      rf_addr_r2 <= rf_addr_r2_d;
      rf_addr_w  <= rf_addr_w_d;
      rf_data_w  <= rf_data_w_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      rdata1_0   <= rdata1_0_d;
      rdata1_1   <= rdata1_1_d;
      rdata2_0   <= rdata2_0_d;
      rdata2_1   <= rdata2_1_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state;
    gnt_d        = gnt;
    rf_read_d    = 1'b0;
    rf_write_d   = 1'b0;
    rf_addr_r1_d = rf_addr_r1;
    rf_addr_r2_d = rf_addr_r2;
    rf_addr_w_d  = rf_addr_w;
    rf_data_w_d  = rf_data_w;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata1_0_d   = rdata1_0;
    rdata1_1_d   = rdata1_1;
    rdata2_0_d   = rdata2_0;
    rdata2_1_d   = rdata2_1;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win;
          state_d = ISSUE;
          if (win) begin
            rf_addr_r1_d = addr_r1_1;
            rf_addr_r2_d = addr_r2_1;
            rf_addr_w_d  = addr_w_1;
            rf_data_w_d  = data_w_1;
            rf_read_d    = ~we1;
            rf_write_d   = we1;
          end else begin
            rf_addr_r1_d = addr_r1_0;
            rf_addr_r2_d = addr_r2_0;
            rf_addr_w_d  = addr_w_0;
            rf_data_w_d  = data_w_0;
            rf_read_d    = ~we0;
            rf_write_d   = we0;
          end
        end
      end
      ISSUE: begin
        // rf_write being high identifies the in-flight transaction as a write.
        if (rf_write) begin
          state_d = DONE;
          ack0_d  = ~gnt;
          ack1_d  = gnt;
        end else begin
          state_d   = CAPTURE;
          rf_read_d = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = DONE;
        ack0_d  = ~gnt;
        ack1_d  = gnt;
        if (gnt) begin
          rdata1_1_d = rf_data_r1;
          rdata2_1_d = rf_data_r2;
        end else begin
          rdata1_0_d = rf_data_r1;
          rdata2_0_d = rf_data_r2;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter with a behavioural register file attached.
module tb_reg_file_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr_r1_0, addr_r1_1, addr_r2_0, addr_r2_1, addr_w_0, addr_w_1;
  logic [31:0] data_w_0, data_w_1;
  logic        ack0, ack1;
  logic [31:0] rdata1_0, rdata1_1, rdata2_0, rdata2_1;
  logic        rf_read, rf_write;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;
  logic        busy, gnt;

  reg_file_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr_r1_0(addr_r1_0), .addr_r1_1(addr_r1_1), .addr_r2_0(addr_r2_0), .addr_r2_1(addr_r2_1),
    .addr_w_0(addr_w_0), .addr_w_1(addr_w_1), .data_w_0(data_w_0), .data_w_1(data_w_1),
    .ack0(ack0), .ack1(ack1), .rdata1_0(rdata1_0), .rdata1_1(rdata1_1),
    .rdata2_0(rdata2_0), .rdata2_1(rdata2_1), .rf_read(rf_read), .rf_write(rf_write),
    .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2), .rf_addr_w(rf_addr_w),
    .rf_data_w(rf_data_w), .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: read data appears after an edge with READ high, garbage otherwise.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_write) mem[rf_addr_w] <= rf_data_w;
    rf_data_r1 <= rf_read ? mem[rf_addr_r1] : 32'hDEAD_BEEF;
    rf_data_r2 <= rf_read ? mem[rf_addr_r2] : 32'hBAD0_BAD0;
  end

  typedef struct {
    int          client;
    bit          is_write;
    logic [31:0] d1;
    logic [31:0] d2;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [32];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each ACK.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rd_wr_exclusive", 32'(rf_read & rf_write), 32'd0);
      chk("single_ack", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack1), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_client", 32'(ack1), 32'(e.client));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.is_write) begin
            chk("rdata1", (e.client == 1) ? rdata1_1 : rdata1_0, e.d1);
            chk("rdata2", (e.client == 1) ? rdata2_1 : rdata2_0, e.d2);
          end
        end
      end
    end
  end

  task automatic drive(input int c, input bit we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] aw, input logic [31:0] d);
    if (c == 0) begin
      we0 = we; addr_r1_0 = a1; addr_r2_0 = a2; addr_w_0 = aw; data_w_0 = d; req0 = 1'b1;
    end else begin
      we1 = we; addr_r1_1 = a1; addr_r2_1 = a2; addr_w_1 = aw; data_w_1 = d; req1 = 1'b1;
    end
  endtask

  function automatic exp_t mk_exp(input int c, input bit we, input logic [4:0] a1,
                                  input logic [4:0] a2, input int g);
    exp_t e;
    e.client   = c;
    e.is_write = we;
    e.d1       = shadow[a1];
    e.d2       = shadow[a2];
    e.cyc      = g + (we ? 1 : 2);
    return e;
  endfunction

  // One serialized transaction; called just after an edge with the DUT idle.
  task automatic txn(input int c, input bit we, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] aw, input logic [31:0] d, input bit alter);
    int nw = 0;
    int nr = 0;
    bit got = 1'b0;
    int g;
    drive(c, we, a1, a2, aw, d);
    g = cyc + 1;
    sb.push_back(mk_exp(c, we, a1, a2, g));
    if (we) shadow[aw] = d;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (rf_write) begin
        nw++;
        chk("rf_addr_w", 32'(rf_addr_w), 32'(aw));
        chk("rf_data_w", rf_data_w, d);
      end
      if (rf_read) begin
        nr++;
        chk("rf_addr_r1", 32'(rf_addr_r1), 32'(a1));
        chk("rf_addr_r2", 32'(rf_addr_r2), 32'(a2));
      end
      if (i == 0 && alter) begin
        if (c == 0) begin addr_w_0 = aw + 5'd1; data_w_0 = ~d; end
        else        begin addr_w_1 = aw + 5'd1; data_w_1 = ~d; end
      end
      got = (c == 0) ? ack0 : ack1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("rf_write_cycles", 32'(nw), we ? 32'd1 : 32'd0);
    chk("rf_read_cycles", 32'(nr), we ? 32'd0 : 32'd2);
    @(posedge clk); #1;
    if (c == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; shadow[i] = '0; end
    we0 = 0; we1 = 0; addr_r1_0 = 0; addr_r1_1 = 0; addr_r2_0 = 0; addr_r2_1 = 0;
    addr_w_0 = 0; addr_w_1 = 0; data_w_0 = 0; data_w_1 = 0;
    do_reset();

    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd1);
    chk("reset_rf_cmd", {30'd0, rf_read, rf_write}, 32'd0);
    chk("reset_rf_addr", {17'd0, rf_addr_r1, rf_addr_r2, rf_addr_w}, 32'd0);
    chk("reset_rf_data_w", rf_data_w, 32'd0);
    chk("reset_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("reset_rdata", rdata1_0 | rdata1_1 | rdata2_0 | rdata2_1, 32'd0);

    txn(0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hA5A5_0005, 1'b0);
    for (int i = 1; i <= 9; i++) txn(0, 1'b1, 5'd0, 5'd0, 5'(i), 32'(i), 1'b0);
    txn(1, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0, 1'b0);
    chk("gnt_after_c1", 32'(gnt), 32'd1);

    // Fields changed after the grant edge must not leak into the transaction.
    txn(0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0000_0055, 1'b1);
    txn(0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd0, 1'b0);
    chk("mem6_untouched", mem[6], 32'd6);

    // Contention from reset with both requests held for four transactions.
    do_reset();
    drive(0, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0);
    drive(1, 1'b0, 5'd1, 5'd9, 5'd0, 32'd0);
    g = cyc + 1;
    for (int k = 0; k < 4; k++) begin
`ifdef REG_ARB_FIXED_PRIORITY_EN
      sb.push_back(mk_exp(0, 1'b0, 5'd3, 5'd7, g + 4 * k));
`else
      if (k % 2 == 0) sb.push_back(mk_exp(0, 1'b0, 5'd3, 5'd7, g + 4 * k));
      else            sb.push_back(mk_exp(1, 1'b0, 5'd1, 5'd9, g + 4 * k));
`endif
    end
    repeat (16) @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Reset during CAPTURE aborts the read with no ACK.
    drive(1, 1'b0, 5'd2, 5'd4, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("capture_rf_read", 32'(rf_read), 32'd1);
    rst_n = 1'b0;
    req1 = 1'b0;
    #1;
    chk("abort_rf_read", 32'(rf_read), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("abort_rdata", rdata1_1, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    txn(1, 1'b0, 5'd2, 5'd4, 5'd0, 32'd0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
          5'($urandom), $urandom, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Two-requester arbiter and access sequencer for the 32x32 dual-read register file (REGISTER_FILE_32x32). It accepts read-pair or write requests from two clients over a req/ack handshake. It drives the register file's READ/WRITE/address/data pins with legal one-hot commands, and captures read data before the register file's outputs go undefined. Clients are the core datapath on port 0 and the debug/loader path on port 1.

Parameters:
DATA_WIDTH, 32, register word width
ADDR_WIDTH, 5, register address width (32 registers)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-low reset
REQ0/REQ1  input  1  request from client 0/1
WE0/WE1  input  1  1 = write, 0 = read pair
ADDR_R1_0/ADDR_R1_1  input  ADDR_WIDTH  read address 1
ADDR_R2_0/ADDR_R2_1  input  ADDR_WIDTH  read address 2
ADDR_W_0/ADDR_W_1  input  ADDR_WIDTH  write address
DATA_W_0/DATA_W_1  input  DATA_WIDTH  write data
ACK0/ACK1  output  1  one-cycle completion pulse
RDATA1_0/RDATA1_1  output  DATA_WIDTH  captured DATA_R1, valid while ACK high and held until next capture for that client
RDATA2_0/RDATA2_1  output  DATA_WIDTH  captured DATA_R2, same validity
RF_READ, RF_WRITE  output  1  to register file READ/WRITE
RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  output  ADDR_WIDTH  to register file
RF_DATA_W  output  DATA_WIDTH  to register file DATA_W
RF_DATA_R1, RF_DATA_R2  input  DATA_WIDTH  from register file
BUSY  output  1  high in any state other than IDLE
GNT  output  1  client currently or last granted (0/1)

Behaviour:
- Reset (RST low, async): state=IDLE. RF_READ=0, RF_WRITE=0. All RF_* address/data=0. ACK0=ACK1=0. RDATA*=0. BUSY=0. GNT=1, so client 0 wins the first contention.
- All outputs are registered; no combinational path from REQ to RF_* or ACK.
- States are IDLE, ISSUE, CAPTURE, DONE.
- IDLE: on an edge with any REQ high, latch the winner's WE/addresses/data into RF_* outputs and set GNT. Go to ISSUE with RF_READ=~WE and RF_WRITE=WE.
- Arbitration is round-robin. With a single request, that client wins. With both requesting, the client != GNT wins.
- ISSUE (1 cycle): the register file acts on the edge ending ISSUE. A write goes to DONE with RF_WRITE=0. A read goes to CAPTURE with RF_READ held at 1.
- CAPTURE (1 cycle): RF_READ stays 1 so RF_DATA_R* is stable. At the end edge, latch RF_DATA_R1/R2 into the granted client's RDATA1/RDATA2, drop RF_READ, and go to DONE.
- DONE (1 cycle): ACK of the granted client is high. Next state is IDLE.
- RF_READ and RF_WRITE are never both 1. Both are 0 in IDLE and DONE.
- Latency, counted from the edge sampling REQ: write ACK is high in the 2nd cycle after it, read ACK in the 3rd. Throughput per client is one transaction per 3 (write) or 4 (read) cycles.
- Handshake: the client holds REQ and its fields stable until it sees ACK, then must deassert REQ in the cycle after ACK. REQ still high in IDLE after DONE is a new request.
- Fields are sampled only at the IDLE grant edge. Changes afterward do not affect the in-flight transaction.
- The losing client's REQ stays pending and is served next. No starvation: in round-robin mode, worst-case wait is one transaction.
- Address 0 and all addresses are passed through unmodified. Register-file semantics are the register file's concern.
- Reset asserted mid-transaction aborts it immediately: RF_READ/WRITE=0, no ACK, and the transaction is not replayed.

Optional Feature:
Macro REG_ARB_FIXED_PRIORITY_EN.
- Defined: client 0 always wins simultaneous requests and GNT does not affect arbitration. GNT still reports the last grant.
- Undefined: round-robin as above.

Test Plan:
- Reset then single write: client 0 REQ0=1, WE0=1, ADDR_W_0=5, DATA_W_0=32'hA5A5_0005 -> RF_WRITE=1 for exactly one cycle with RF_ADDR_W=5, and ACK0 2 cycles after the grant edge. RF_READ stays 0 throughout.
- Read pair: after writes of i to regs 1..9, client 1 reads ADDR_R1_1=3, ADDR_R2_1=7 -> ACK1 3 cycles after grant with RDATA1_1=32'h3 and RDATA2_1=32'h7. RF_READ is high for exactly 2 cycles.
- Contention: REQ0 and REQ1 both rise together after reset, both reads -> client 0 is served first, then client 1. Repeating with both held produces grants alternating 0,1,0,1. With REG_ARB_FIXED_PRIORITY_EN and REQ0 re-asserted immediately, client 0 is served repeatedly.
- Field stability: change ADDR_W_0 from 5 to 6 one cycle after the grant edge -> the write still goes to address 5.
- Reset mid-read: pull RST low during CAPTURE -> RF_READ=0, BUSY=0, no ACK. After release, a new request completes normally.
- Protocol invariant over 1000 random requests: RF_READ&RF_WRITE never 1, at most one ACK per cycle, and every RDATA matches a shadow model.
